// File: rtl/fsmc_pkg.sv
// Shared types and defaults for the FSMC register arbiter slice.
package fsmc_pkg;

    localparam int unsigned ADRW_DEF   = 2;
    localparam int unsigned DATW_DEF   = 8;
    localparam int unsigned LOCK_CNT_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_GNT   = 4'b0010,
        ST_LOCK  = 4'b0100,
        ST_DRAIN = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/fsmc_reg_bank.sv
// Register bank with two write ports (port A wins on equal address),
// two combinational read ports and a flat view of every register.
module fsmc_reg_bank
    import fsmc_pkg::*;
#(
    parameter int unsigned ADRW = ADRW_DEF,
    parameter int unsigned DATW = DATW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_we,
    input  logic [ADRW-1:0]              a_adr,
    input  logic [DATW-1:0]              a_wdata,
    input  logic                         b_we,
    input  logic [ADRW-1:0]              b_adr,
    input  logic [DATW-1:0]              b_wdata,
    input  logic [ADRW-1:0]              a_radr,
    output logic [DATW-1:0]              a_rdata,
    input  logic [ADRW-1:0]              b_radr,
    output logic [DATW-1:0]              b_rdata,
    output logic [(2**ADRW)*DATW-1:0]    regs_flat
);

    localparam int unsigned NREG = 2**ADRW;

    logic [DATW-1:0] regs_q [NREG];
    logic [DATW-1:0] regs_d [NREG];

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (b_we) begin
            regs_d[b_adr] = b_wdata;
        end
        // Port A is applied last so it overrides port B on the same address.
        if (a_we) begin
            regs_d[a_adr] = a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_flat[i*DATW +: DATW] = regs_q[i];
        end
    end

    assign a_rdata = regs_q[a_radr];
    assign b_rdata = regs_q[b_radr];

endmodule

// File: rtl/fsmc_reg_arbiter.sv
// Shares the FSMC register bank between the unstallable bus slave and one
// internal req/gnt requester with optional lock and a one-entry defer slot.
module fsmc_reg_arbiter
    import fsmc_pkg::*;
#(
    parameter int unsigned ADRW     = ADRW_DEF,
    parameter int unsigned DATW     = DATW_DEF,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_do_write,
    input  logic [ADRW-1:0]              bus_adr,
    input  logic [DATW-1:0]              bus_wdata,
    output logic [DATW-1:0]              bus_rdata,
    input  logic                         int_req,
    input  logic                         int_we,
    input  logic                         int_lock,
    input  logic [ADRW-1:0]              int_adr,
    input  logic [DATW-1:0]              int_wdata,
    output logic                         int_gnt,
    output logic [DATW-1:0]              int_rdata,
    output logic                         int_lost,
    output logic                         defer_ovf,
    output logic                         lock_tmo,
    input  logic                         flag_clr,
    output logic [(2**ADRW)*DATW-1:0]    regs_flat
);

    arb_state_e            state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
    logic                  slot_vld_q, slot_vld_d;
    logic [ADRW-1:0]       slot_adr_q, slot_adr_d;
    logic [DATW-1:0]       slot_dat_q, slot_dat_d;
    logic                  int_gnt_q, int_gnt_d;
    logic                  int_lost_q, int_lost_d;
    logic                  defer_ovf_q, defer_ovf_d;
    logic                  lock_tmo_q, lock_tmo_d;

    logic                  a_we, b_we, int_wr;
    logic [ADRW-1:0]       b_adr;
    logic [DATW-1:0]       b_wdata;
    logic                  ovf_set, tmo_set, tmo_hit;

    assign lock_cnt_inc = lock_cnt_q + LOCK_CNT_W'(1);
    assign tmo_hit      = (lock_cnt_inc == LOCK_CNT_W'(LOCK_MAX)) && int_lock;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        slot_vld_d = slot_vld_q;
        slot_adr_d = slot_adr_q;
        slot_dat_d = slot_dat_q;
        a_we       = bus_do_write;
        b_we       = 1'b0;
        b_adr      = int_adr;
        b_wdata    = int_wdata;
        int_wr     = 1'b0;
        ovf_set    = 1'b0;
        tmo_set    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (int_req && !bus_do_write && !slot_vld_q) begin
                    state_d = ST_GNT;
                end
            end
            ST_GNT: begin
                int_wr = int_we;
                if (int_lock) begin
                    state_d    = ST_LOCK;
                    lock_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                int_wr     = int_we;
                lock_cnt_d = lock_cnt_inc;
                // Bus writes to the locked address are parked, not applied.
                if (bus_do_write && (bus_adr == int_adr)) begin
                    a_we       = 1'b0;
                    ovf_set    = slot_vld_q;
                    slot_vld_d = 1'b1;
                    slot_adr_d = bus_adr;
                    slot_dat_d = bus_wdata;
                end
                if (!int_lock || tmo_hit) begin
                    state_d = slot_vld_d ? ST_DRAIN : ST_IDLE;
                    tmo_set = tmo_hit;
                end
            end
            ST_DRAIN: begin
                b_we       = 1'b1;
                b_adr      = slot_adr_q;
                b_wdata    = slot_dat_q;
                slot_vld_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (int_wr) begin
            b_we = 1'b1;
        end

        int_lost_d  = int_wr && a_we && (bus_adr == int_adr);
        int_gnt_d   = (state_d == ST_GNT) || (state_d == ST_LOCK);
        defer_ovf_d = ovf_set || (defer_ovf_q && !flag_clr);
        lock_tmo_d  = tmo_set || (lock_tmo_q && !flag_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= '0;
            slot_vld_q  <= 1'b0;
            slot_adr_q  <= '0;
            slot_dat_q  <= '0;
            int_gnt_q   <= 1'b0;
            int_lost_q  <= 1'b0;
            defer_ovf_q <= 1'b0;
            lock_tmo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            slot_vld_q  <= slot_vld_d;
            slot_adr_q  <= slot_adr_d;
            slot_dat_q  <= slot_dat_d;
            int_gnt_q   <= int_gnt_d;
            int_lost_q  <= int_lost_d;
            defer_ovf_q <= defer_ovf_d;
            lock_tmo_q  <= lock_tmo_d;
        end
    end

    assign int_gnt   = int_gnt_q;
    assign int_lost  = int_lost_q;
    assign defer_ovf = defer_ovf_q;
    assign lock_tmo  = lock_tmo_q;

    fsmc_reg_bank #(
        .ADRW (ADRW),
        .DATW (DATW)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .a_we      (a_we),
        .a_adr     (bus_adr),
        .a_wdata   (bus_wdata),
        .b_we      (b_we),
        .b_adr     (b_adr),
        .b_wdata   (b_wdata),
        .a_radr    (bus_adr),
        .a_rdata   (bus_rdata),
        .b_radr    (int_adr),
        .b_rdata   (int_rdata),
        .regs_flat (regs_flat)
    );

endmodule

// File: tb/tb_fsmc_reg_arbiter.sv
// Directed self-checking bench for fsmc_reg_arbiter (ADRW=2, DATW=8, LOCK_MAX=15).
module tb_fsmc_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_do_write;
    logic [1:0]  bus_adr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        int_req, int_we, int_lock;
    logic [1:0]  int_adr;
    logic [7:0]  int_wdata;
    logic        int_gnt;
    logic [7:0]  int_rdata;
    logic        int_lost, defer_ovf, lock_tmo, flag_clr;
    logic [31:0] regs_flat;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    fsmc_reg_arbiter #(
        .ADRW     (2),
        .DATW     (8),
        .LOCK_MAX (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_do_write (bus_do_write),
        .bus_adr      (bus_adr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .int_req      (int_req),
        .int_we       (int_we),
        .int_lock     (int_lock),
        .int_adr      (int_adr),
        .int_wdata    (int_wdata),
        .int_gnt      (int_gnt),
        .int_rdata    (int_rdata),
        .int_lost     (int_lost),
        .defer_ovf    (defer_ovf),
        .lock_tmo     (lock_tmo),
        .flag_clr     (flag_clr),
        .regs_flat    (regs_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] adr, input logic [7:0] dat);
        bus_do_write = 1'b1;
        bus_adr      = adr;
        bus_wdata    = dat;
        step();
        bus_do_write = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        rst = 1'b1; bus_do_write = 1'b0; bus_adr = '0; bus_wdata = '0;
        int_req = 1'b0; int_we = 1'b0; int_lock = 1'b0; int_adr = '0;
        int_wdata = '0; flag_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_gnt", int_gnt, 0);
        check("rst_lost", int_lost, 0);
        check("rst_ovf", defer_ovf, 0);
        check("rst_tmo", lock_tmo, 0);
        check("rst_regs", regs_flat, 32'h0);

        // Bus write then read back
        bus_wr(2'd1, 8'h5A);
        bus_adr = 2'd1; #1;
        check("rd_reg1", bus_rdata, 8'h5A);
        check("regs_after_bus", regs_flat, 32'h0000_5A00);

        // Grant delayed by a coincident bus write
        int_req = 1'b1; int_we = 1'b1; int_adr = 2'd2; int_wdata = 8'h11;
        bus_wr(2'd0, 8'h77);
        check("gnt_blocked", int_gnt, 0);
        step();
        check("gnt_late", int_gnt, 1);
        int_req = 1'b0;
        step();
        int_we = 1'b0;
        check("gnt_drop", int_gnt, 0);
        check("int_rd_reg2", int_rdata, 8'h11);
        check("regs_collide", regs_flat, 32'h0011_5A77);

        // Same-address conflict in GNT: bus wins, int_lost pulses
        int_req = 1'b1; int_we = 1'b1; int_adr = 2'd0; int_wdata = 8'h22;
        step();
        check("gnt_conf", int_gnt, 1);
        int_req = 1'b0;
        bus_wr(2'd0, 8'h33);
        int_we = 1'b0;
        check("lost_pulse", int_lost, 1);
        check("regs_conf", regs_flat, 32'h0011_5A33);
        step();
        check("lost_clear", int_lost, 0);

        // Locked RMW with deferral
        int_req = 1'b1; int_lock = 1'b1; int_adr = 2'd3;
        step();
        int_req = 1'b0;
        step();
        check("lock_gnt", int_gnt, 1);
        bus_wr(2'd3, 8'h44);
        check("ovf_first", defer_ovf, 0);
        bus_wr(2'd3, 8'h55);
        bus_wr(2'd1, 8'h66);
        bus_adr = 2'd3; #1;
        check("lock_reg3_rd", bus_rdata, 8'h00);
        check("lock_regs", regs_flat, 32'h0011_6633);
        check("lock_ovf", defer_ovf, 1);
        int_we = 1'b1; int_wdata = 8'h99;
        step();
        int_we = 1'b0;
        check("lock_int_wr", int_rdata, 8'h99);
        int_lock = 1'b0;
        step();
        check("drain_gnt", int_gnt, 0);
        check("pre_drain", regs_flat, 32'h9911_6633);
        step();
        check("post_drain", regs_flat, 32'h5511_6633);
        check("drain_tmo", lock_tmo, 0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("ovf_clr", defer_ovf, 0);

        // Lock timeout after LOCK_MAX cycles
        int_req = 1'b1; int_lock = 1'b1; int_adr = 2'd2;
        step();
        int_req = 1'b0;
        step();
        check("tmo_gnt", int_gnt, 1);
        cyc = 0;
        while (int_gnt && cyc < 40) begin
            step();
            cyc++;
        end
        check("tmo_cycles", cyc, 15);
        check("tmo_flag", lock_tmo, 1);
        repeat (3) step();
        int_lock = 1'b0;
        check("tmo_idle", int_gnt, 0);
        check("tmo_regs", regs_flat, 32'h5511_6633);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("tmo_clr", lock_tmo, 0);

        // Reset while LOCK holds a valid slot
        int_req = 1'b1; int_lock = 1'b1; int_adr = 2'd3;
        step();
        int_req = 1'b0;
        step();
        bus_wr(2'd3, 8'hEE);
        rst = 1'b1; int_lock = 1'b0;
        step();
        rst = 1'b0;
        check("rstlk_regs", regs_flat, 32'h0);
        step(); step();
        check("rstlk_nodrain", regs_flat, 32'h0);
        check("rstlk_gnt", int_gnt, 0);
        int_req = 1'b1;
        step();
        check("rstlk_idle", int_gnt, 1);
        int_req = 1'b0;
        step();
        check("rstlk_end", int_gnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
